// File: rtl/biphasic_train_gen_if.sv
// Control-register to switch-matrix bundle for the biphasic train generator.
// The master side programs timing/enable; the slave side (the generator) drives the switches.
interface biphasic_train_gen_if #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 16,
  parameter int GAP_W   = 24,
  parameter int REPS_W  = 17,
  parameter int TRAIN_W = 8
);
  logic               enable;
  logic [CNT_W-1:0]   phase_len;
  logic [CNT_W-1:0]   interphase_len;
  logic [CNT_W-1:0]   interpulse_len;
  logic [REPS_W-1:0]  reps;
  logic [GAP_W-1:0]   intertrain_len;
  logic [TRAIN_W-1:0] num_trains;
  logic [NCH-1:0]     ch_mask;
  logic [NCH-1:0]     ch_pol;
  logic [NCH-1:0]     A;
  logic [NCH-1:0]     B;
  logic [NCH-1:0]     C;
  logic               busy;
  logic               done;
  logic [REPS_W-1:0]  pulse_idx;

  modport master (
    output enable, phase_len, interphase_len, interpulse_len, reps,
           intertrain_len, num_trains, ch_mask, ch_pol,
    input  A, B, C, busy, done, pulse_idx
  );

  modport slave (
    input  enable, phase_len, interphase_len, interpulse_len, reps,
           intertrain_len, num_trains, ch_mask, ch_pol,
    output A, B, C, busy, done, pulse_idx
  );
endinterface

// File: rtl/biphasic_train_gen.sv
// Multi-channel charge-balanced biphasic pulse-train sequencer; timing, mask and polarity
// are latched at start, outputs are registered one cycle after the decision edge.
module biphasic_train_gen #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 16,
  parameter int GAP_W   = 24,
  parameter int REPS_W  = 17,
  parameter int TRAIN_W = 8
) (
  input logic                clk,
  input logic                reset,
  biphasic_train_gen_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PH1  = 3'd1;
  localparam logic [2:0] S_IPG  = 3'd2;
  localparam logic [2:0] S_PH2  = 3'd3;
  localparam logic [2:0] S_IPI  = 3'd4;
  localparam logic [2:0] S_ITG  = 3'd5;

  localparam logic [GAP_W-1:0]   ONE_G = {{(GAP_W-1){1'b0}}, 1'b1};
  localparam logic [REPS_W-1:0]  ONE_R = {{(REPS_W-1){1'b0}}, 1'b1};
  localparam logic [TRAIN_W-1:0] ONE_T = {{(TRAIN_W-1){1'b0}}, 1'b1};

  logic [2:0]         state, nxt;
  logic [GAP_W-1:0]   cnt, cnt_nxt;
  logic [REPS_W-1:0]  pidx, pidx_nxt;
  logic [TRAIN_W-1:0] tcnt, tcnt_nxt;
  logic               stop, rearm;

  logic [CNT_W-1:0]   l_phase, l_ipg, l_ipi;
  logic [GAP_W-1:0]   l_itg;
  logic [REPS_W-1:0]  l_reps;
  logic [TRAIN_W-1:0] l_trains;
  logic [NCH-1:0]     l_mask, l_pol;

  logic               start, seg_end, last_pulse, last_train, rearm_set;
  logic [CNT_W-1:0]   phase_src;
  logic [GAP_W-1:0]   ph_load;
  logic [NCH-1:0]     mask_src, pol_src, a_nxt, b_nxt;

  assign start      = (state == S_IDLE) && bus.enable && !rearm;
  assign seg_end    = (cnt == '0);
  assign last_pulse = (pidx >= l_reps);
  assign last_train = (l_trains != '0) && (tcnt >= l_trains);
  assign rearm_set  = (state == S_PH2) && seg_end && last_pulse && last_train;

  // The start edge must use the live inputs since the latches load on that same edge.
  assign phase_src = (state == S_IDLE) ? bus.phase_len : l_phase;
  assign mask_src  = (state == S_IDLE) ? bus.ch_mask : l_mask;
  assign pol_src   = (state == S_IDLE) ? bus.ch_pol : l_pol;
  assign ph_load   = (phase_src == '0) ? '0 : GAP_W'(phase_src) - ONE_G;

  always_comb begin
    nxt      = state;
    cnt_nxt  = seg_end ? cnt : cnt - ONE_G;
    pidx_nxt = pidx;
    tcnt_nxt = tcnt;
    case (state)
      S_IDLE: if (start) begin
        nxt      = S_PH1;
        cnt_nxt  = ph_load;
        pidx_nxt = ONE_R;
        tcnt_nxt = ONE_T;
      end
      S_PH1: if (seg_end) begin
        if (l_ipg != '0) begin
          nxt     = S_IPG;
          cnt_nxt = GAP_W'(l_ipg) - ONE_G;
        end else begin
          nxt     = S_PH2;
          cnt_nxt = ph_load;
        end
      end
      S_IPG: if (seg_end) begin
        nxt     = S_PH2;
        cnt_nxt = ph_load;
      end
      S_PH2: if (seg_end) begin
        if (stop || !bus.enable || (last_pulse && last_train)) begin
          nxt = S_IDLE;
        end else if (!last_pulse) begin
          if (l_ipi != '0) begin
            nxt     = S_IPI;
            cnt_nxt = GAP_W'(l_ipi) - ONE_G;
          end else begin
            nxt      = S_PH1;
            cnt_nxt  = ph_load;
            pidx_nxt = pidx + ONE_R;
          end
        end else if (l_itg != '0) begin
          nxt     = S_ITG;
          cnt_nxt = l_itg - ONE_G;
        end else begin
          nxt      = S_PH1;
          cnt_nxt  = ph_load;
          pidx_nxt = ONE_R;
          tcnt_nxt = (tcnt == '1) ? tcnt : tcnt + ONE_T;
        end
      end
      S_IPI: if (!bus.enable) begin
        nxt = S_IDLE;
      end else if (seg_end) begin
        nxt      = S_PH1;
        cnt_nxt  = ph_load;
        pidx_nxt = pidx + ONE_R;
      end
      S_ITG: if (!bus.enable) begin
        nxt = S_IDLE;
      end else if (seg_end) begin
        nxt      = S_PH1;
        cnt_nxt  = ph_load;
        pidx_nxt = ONE_R;
        tcnt_nxt = (tcnt == '1) ? tcnt : tcnt + ONE_T;
      end
      default: nxt = S_IDLE;
    endcase
    if (nxt == S_IDLE) begin
      cnt_nxt  = '0;
      pidx_nxt = '0;
      tcnt_nxt = '0;
    end
  end

  assign a_nxt = mask_src & (({NCH{nxt == S_PH1}} & ~pol_src) | ({NCH{nxt == S_PH2}} & pol_src));
  assign b_nxt = mask_src & (({NCH{nxt == S_PH1}} & pol_src) | ({NCH{nxt == S_PH2}} & ~pol_src));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pidx     <= '0;
      tcnt     <= '0;
      stop     <= 1'b0;
      rearm    <= 1'b0;
      bus.A    <= '0;
      bus.B    <= '0;
      bus.C    <= '1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      pidx  <= pidx_nxt;
      tcnt  <= tcnt_nxt;
      // A drop anywhere inside a pulse is remembered so the pulse still balances.
      if (nxt == S_IDLE)
        stop <= 1'b0;
      else if (!bus.enable && (state == S_PH1 || state == S_IPG || state == S_PH2))
        stop <= 1'b1;
      if (!bus.enable)
        rearm <= 1'b0;
      else if (rearm_set)
        rearm <= 1'b1;
      if (start) begin
        l_phase  <= bus.phase_len;
        l_ipg    <= bus.interphase_len;
        l_ipi    <= bus.interpulse_len;
        l_itg    <= bus.intertrain_len;
        l_reps   <= bus.reps;
        l_trains <= bus.num_trains;
        l_mask   <= bus.ch_mask;
        l_pol    <= bus.ch_pol;
      end
      bus.A    <= a_nxt;
      bus.B    <= b_nxt;
      bus.C    <= ~a_nxt & ~b_nxt;
      bus.busy <= (nxt != S_IDLE);
      bus.done <= (nxt == S_IDLE) && (state != S_IDLE);
    end
  end

  assign bus.pulse_idx = pidx;
endmodule

// File: tb/tb_biphasic_train_gen.sv
// Bench for biphasic_train_gen: a timeline model expands each train into per-cycle segments,
// stimulus pushes expected outputs per edge and an independent monitor pops and compares.
module tb_biphasic_train_gen;
  localparam int NCH = 4, CNT_W = 16, GAP_W = 24, REPS_W = 17, TRAIN_W = 8;
  localparam int K_PH1 = 1, K_IPG = 2, K_PH2 = 3, K_IPI = 4, K_ITG = 5;

  typedef struct { int kind; int pidx; int ser; } ent_t;
  typedef struct {
    logic [NCH-1:0] a, b, c;
    bit busy, done;
    int pidx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0, bad = 0, cyc_no = 0;

  biphasic_train_gen_if #(.NCH(NCH), .CNT_W(CNT_W), .GAP_W(GAP_W),
                          .REPS_W(REPS_W), .TRAIN_W(TRAIN_W)) bus ();

  biphasic_train_gen #(.NCH(NCH), .CNT_W(CNT_W), .GAP_W(GAP_W),
                       .REPS_W(REPS_W), .TRAIN_W(TRAIN_W)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state: remaining per-cycle timeline of the current run.
  ent_t tl[$];
  ent_t cur;
  exp_t expq[$];
  bit   running = 0, stopping = 0, cut = 0, rearm = 0;
  int   train_no = 0, ser_ctr = 0;
  int   m_phase, m_ipg, m_ipi, m_itg, m_reps, m_trains;
  logic [NCH-1:0] m_mask, m_pol;

  function automatic void build_train(bit with_itg);
    int ph = (m_phase == 0) ? 1 : m_phase;
    int rp = (m_reps == 0) ? 1 : m_reps;
    if (with_itg) repeat (m_itg) tl.push_back('{K_ITG, rp, 0});
    for (int p = 1; p <= rp; p++) begin
      ser_ctr++;
      if (p > 1) repeat (m_ipi) tl.push_back('{K_IPI, p - 1, ser_ctr});
      repeat (ph)    tl.push_back('{K_PH1, p, ser_ctr});
      repeat (m_ipg) tl.push_back('{K_IPG, p, ser_ctr});
      repeat (ph)    tl.push_back('{K_PH2, p, ser_ctr});
    end
  endfunction

  task automatic model_step();
    bit   en = bus.enable;
    exp_t e;
    e.done = 0;
    if (!rst_n) begin
      running = 0; stopping = 0; rearm = 0; tl.delete();
    end else if (!running) begin
      if (!en) rearm = 0;
      else if (!rearm) begin
        m_phase = int'(bus.phase_len);      m_ipg = int'(bus.interphase_len);
        m_ipi   = int'(bus.interpulse_len); m_itg = int'(bus.intertrain_len);
        m_reps  = int'(bus.reps);           m_trains = int'(bus.num_trains);
        m_mask  = bus.ch_mask;              m_pol = bus.ch_pol;
        running = 1; stopping = 0; cut = 0; train_no = 1;
        build_train(0);
        cur = tl.pop_front();
      end
    end else begin
      if (!en) begin
        rearm = 0;
        stopping = 1;
        if (cur.kind <= K_PH2) begin
          int n = 0;
          while (n < tl.size() && tl[n].ser == cur.ser && tl[n].kind <= K_PH2) n++;
          if (tl.size() > n) cut = 1;
          while (tl.size() > n) tl.delete(tl.size() - 1);
        end else tl.delete();
      end
      if (tl.size() == 0) begin
        bit fin = (m_trains != 0) && (train_no >= m_trains);
        if (stopping || fin) begin
          running = 0;
          e.done = 1;
          if (fin && !cut && en) rearm = 1;
        end else begin
          train_no++;
          build_train(1);
        end
      end
      if (running) cur = tl.pop_front();
    end
    e.a = '0; e.b = '0; e.busy = running; e.pidx = running ? cur.pidx : 0;
    if (running) begin
      for (int ch = 0; ch < NCH; ch++) begin
        // Polarity picks which switch carries the first phase; the other carries the second.
        bit first_is_a = !m_pol[ch];
        if (m_mask[ch] && cur.kind == K_PH1) begin
          if (first_is_a) e.a[ch] = 1'b1; else e.b[ch] = 1'b1;
        end
        if (m_mask[ch] && cur.kind == K_PH2) begin
          if (first_is_a) e.b[ch] = 1'b1; else e.a[ch] = 1'b1;
        end
      end
    end
    e.c = ~(e.a | e.b);
    expq.push_back(e);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc_no, act, want);
    end
  endtask

  // Monitor: every output cycle consumes one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty at cycle %0d: got 0 entries want 1", cyc_no);
      end else begin
        e = expq.pop_front();
        check("A", 32'(bus.A), 32'(e.a));
        check("B", 32'(bus.B), 32'(e.b));
        check("C", 32'(bus.C), 32'(e.c));
        check("busy", 32'(bus.busy), 32'(e.busy));
        check("done", 32'(bus.done), 32'(e.done));
        check("pulse_idx", 32'(bus.pulse_idx), 32'(e.pidx));
        check("ab_overlap", 32'(bus.A & bus.B), 32'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    cyc_no++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic cfg(input int ph, ipg, ipi, rp, itg, tr, input logic [NCH-1:0] mask, pol);
    bus.phase_len      = CNT_W'(ph);
    bus.interphase_len = CNT_W'(ipg);
    bus.interpulse_len = CNT_W'(ipi);
    bus.reps           = REPS_W'(rp);
    bus.intertrain_len = GAP_W'(itg);
    bus.num_trains     = TRAIN_W'(tr);
    bus.ch_mask        = mask;
    bus.ch_pol         = pol;
  endtask

  initial begin
    bus.enable = 1'b0;
    cfg(3, 2, 4, 2, 0, 1, 4'b0011, 4'b0001);
    run(3);
    rst_n = 1'b1;
    run(2);

    // Two-pulse single train, then enable held high: no restart.
    bus.enable = 1'b1;
    run(30);
    bus.enable = 1'b0;
    run(2);

    // Enable dropped early in PH1: the pulse still completes.
    bus.enable = 1'b1;
    run(2);
    bus.enable = 1'b0;
    run(12);

    // No gaps, phase 1: PH1/PH2 alternate every cycle.
    cfg(1, 0, 0, 3, 0, 2, 4'b1111, 4'b0101);
    bus.enable = 1'b1;
    run(16);
    bus.enable = 1'b0;
    run(2);

    // Zero phase and zero reps behave as one.
    cfg(0, 1, 1, 0, 0, 1, 4'b1111, 4'b1100);
    bus.enable = 1'b1;
    run(6);
    bus.enable = 1'b0;
    run(2);

    // Masked channels stay discharged; config changes mid-run are ignored.
    cfg(2, 1, 2, 2, 0, 1, 4'b1010, 4'b0110);
    bus.enable = 1'b1;
    run(2);
    cfg(5, 5, 5, 5, 5, 5, 4'b1111, 4'b0000);
    run(20);
    bus.enable = 1'b0;
    run(2);

    // Reset in PH1, enable held: restart after release.
    cfg(3, 2, 4, 2, 0, 1, 4'b0011, 4'b0001);
    bus.enable = 1'b1;
    run(2);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    run(24);
    bus.enable = 1'b0;
    run(2);

    // Unlimited trains with a 5-cycle intertrain gap.
    cfg(1, 1, 1, 2, 5, 0, 4'b1111, 4'b1001);
    bus.enable = 1'b1;
    run(60);
    bus.enable = 1'b0;
    run(3);

    // Randomised stimulus against the timeline model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 3),
            NCH'($urandom), NCH'($urandom));
      if ($urandom_range(0, 19) == 0) bus.enable = ~bus.enable;
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      cyc();
    end

    rst_n = 1'b1;
    bus.enable = 1'b0;
    run(40);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
